// File: rtl/ann_neuron_reduce.sv
// Reduces LANES MAC partial sums plus a bias with one shared adder, saturates, and applies a piecewise-linear sigmoid.
// Optional ANN_REDUCE_BYPASS_EN adds iAct_bypass, which returns the saturated sum instead of the activation.
module ann_neuron_reduce #(
  parameter int LANES  = 20,
  parameter int DATA_W = 32
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic [LANES*DATA_W-1:0] iData_in,
  input  logic [DATA_W-1:0]       iBias,
  input  logic [LANES-1:0]        iLane_mask,
`ifdef ANN_REDUCE_BYPASS_EN
  input  logic                    iAct_bypass,
`endif
  output logic [DATA_W-1:0]       oResult,
  output logic                    oValid,
  output logic                    oBusy,
  output logic                    oDrop,
  output logic [1:0]              oDbg_state
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACC_W = DATA_W + $clog2(LANES) + 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Breakpoints on |x| (Q16.16, one extra bit so |min| fits) and segment offsets.
  localparam logic [DATA_W:0]   A_HI  = (DATA_W+1)'('h0005_0000);
  localparam logic [DATA_W:0]   A_MID = (DATA_W+1)'('h0002_6000);
  localparam logic [DATA_W:0]   A_LO  = (DATA_W+1)'('h0001_0000);
  localparam logic [DATA_W-1:0] Y_ONE = DATA_W'('h0001_0000);
  localparam logic [DATA_W-1:0] Y_HI  = DATA_W'('h0000_D800);
  localparam logic [DATA_W-1:0] Y_MID = DATA_W'('h0000_A000);
  localparam logic [DATA_W-1:0] Y_LO  = DATA_W'('h0000_8000);

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, ACT} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [LANES*DATA_W-1:0] r_lanes;
  logic [LANES-1:0]        r_mask;
  logic [ACC_W-1:0]        r_acc;
  logic [DATA_W-1:0]       r_x;
  logic [DATA_W-1:0]       r_result;
  logic                    r_valid;
  logic                    r_drop;
`ifdef ANN_REDUCE_BYPASS_EN
  logic                    r_bypass;
`endif

  logic [DATA_W-1:0] w_lane;
  logic [ACC_W-1:0]  w_addend;
  logic [ACC_W-1:0]  w_bias_ext;
  logic [DATA_W-1:0] w_x;
  logic              w_neg;
  logic [DATA_W:0]   w_a;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_act;

  // Lanes shift down one slot per ACCUM cycle, so lane[counter] is always the low word.
  assign w_lane     = r_lanes[DATA_W-1:0];
  assign w_addend   = r_mask[0] ? {{(ACC_W-DATA_W){w_lane[DATA_W-1]}}, w_lane} : '0;
  assign w_bias_ext = {{(ACC_W-DATA_W){iBias[DATA_W-1]}}, iBias};

  always_comb begin
    w_x = r_acc[DATA_W-1:0];
    if ($signed(r_acc) > $signed(SAT_MAX)) begin
      w_x = {1'b0, {(DATA_W-1){1'b1}}};
    end else if ($signed(r_acc) < $signed(SAT_MIN)) begin
      w_x = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  assign w_neg = r_x[DATA_W-1];
  assign w_a   = w_neg ? ((DATA_W+1)'(0) - {r_x[DATA_W-1], r_x}) : {1'b0, r_x};

  always_comb begin
    if (w_a >= A_HI) begin
      w_y = Y_ONE;
    end else if (w_a >= A_MID) begin
      w_y = DATA_W'(w_a >> 5) + Y_HI;
    end else if (w_a >= A_LO) begin
      w_y = DATA_W'(w_a >> 3) + Y_MID;
    end else begin
      w_y = DATA_W'(w_a >> 2) + Y_LO;
    end
  end

  assign w_act = w_neg ? (Y_ONE - w_y) : w_y;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_lanes  <= '0;
      r_mask   <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_drop   <= 1'b0;
`ifdef ANN_REDUCE_BYPASS_EN
      r_bypass <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_drop  <= iStart && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_lanes  <= iData_in;
            r_mask   <= iLane_mask;
            r_acc    <= w_bias_ext;
            r_cnt    <= '0;
`ifdef ANN_REDUCE_BYPASS_EN
            r_bypass <= iAct_bypass;
`endif
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc   <= r_acc + w_addend;
          r_lanes <= r_lanes >> DATA_W;
          r_mask  <= r_mask >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_LANE) begin
            r_state <= SAT;
          end
        end
        SAT: begin
          r_x     <= w_x;
          r_state <= ACT;
        end
        ACT: begin
`ifdef ANN_REDUCE_BYPASS_EN
          r_result <= r_bypass ? r_x : w_act;
`else
          r_result <= w_act;
`endif
          r_valid  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oResult    = r_result;
  assign oValid     = r_valid;
  assign oBusy      = (r_state != IDLE);
  assign oDrop      = r_drop;
  assign oDbg_state = r_state;

endmodule

// File: tb/tb_ann_neuron_reduce.sv
// Directed and randomized checks of ann_neuron_reduce against an arithmetic reference model.
module tb_ann_neuron_reduce;
  localparam int LANES  = 20;
  localparam int DATA_W = 32;

  logic                    iClk = 1'b0;
  logic                    iReset;
  logic                    iStart;
  logic [LANES*DATA_W-1:0] iData_in;
  logic [DATA_W-1:0]       iBias;
  logic [LANES-1:0]        iLane_mask;
`ifdef ANN_REDUCE_BYPASS_EN
  logic                    iAct_bypass;
`endif
  logic [DATA_W-1:0]       oResult;
  logic                    oValid;
  logic                    oBusy;
  logic                    oDrop;
  logic [1:0]              oDbg_state;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] m_lanes [LANES];
  logic [LANES-1:0]  m_mask;
  logic [DATA_W-1:0] m_bias;
  logic              m_bypass;
  logic [DATA_W-1:0] exp_prev;

  ann_neuron_reduce #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .iData_in   (iData_in),
    .iBias      (iBias),
    .iLane_mask (iLane_mask),
`ifdef ANN_REDUCE_BYPASS_EN
    .iAct_bypass(iAct_bypass),
`endif
    .oResult    (oResult),
    .oValid     (oValid),
    .oBusy      (oBusy),
    .oDrop      (oDrop),
    .oDbg_state (oDbg_state)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer sum, clamp, then the sigmoid segments in plain arithmetic.
  function automatic logic [31:0] model_result();
    longint sum, x, a, y;
    sum = longint'($signed(m_bias));
    for (int i = 0; i < LANES; i++) begin
      if (m_mask[i]) sum += longint'($signed(m_lanes[i]));
    end
    if (sum > 64'sd2147483647) x = 64'sd2147483647;
    else if (sum < -64'sd2147483648) x = -64'sd2147483648;
    else x = sum;
`ifdef ANN_REDUCE_BYPASS_EN
    if (m_bypass) return 32'(x);
`endif
    a = (x < 0) ? -x : x;
    if (a >= 5 * 65536) y = 65536;
    else if (a >= 155648) y = a / 32 + 'hD800;
    else if (a >= 65536) y = a / 8 + 'hA000;
    else y = a / 4 + 'h8000;
    if (x < 0) y = 65536 - y;
    return 32'(y);
  endfunction

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < LANES; i++) m_lanes[i] = v;
  endtask

  task automatic load_inputs();
    for (int i = 0; i < LANES; i++) iData_in[i*DATA_W +: DATA_W] = m_lanes[i];
    iBias      = m_bias;
    iLane_mask = m_mask;
`ifdef ANN_REDUCE_BYPASS_EN
    iAct_bypass = m_bypass;
`endif
  endtask

  // Called #1 after an edge with the block idle; returns #1 after the oValid edge.
  task automatic run_neuron(input string tag, input logic [31:0] expv);
    int n;
    bit seen;
    load_inputs();
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    check({tag, " busy"}, 32'(oBusy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge iClk); #1;
      n++;
      if (n == 11) check({tag, " hold"}, oResult, exp_prev);
      seen = oValid;
    end
    check({tag, " latency"}, 32'(n), 32'd22);
    check({tag, " result"}, oResult, expv);
    exp_prev = expv;
  endtask

  initial begin
    int n, vcnt, vn, drops, drop_n;
    logic [31:0] vres;
    iReset = 1'b1;
    iStart = 1'b0;
    iData_in = '0;
    iBias = '0;
    iLane_mask = '0;
    m_bypass = 1'b0;
    m_bias = '0;
    m_mask = '1;
    exp_prev = '0;
`ifdef ANN_REDUCE_BYPASS_EN
    iAct_bypass = 1'b0;
`endif
    repeat (3) @(posedge iClk);
    #1;
    check("reset oResult", oResult, 32'h0);
    check("reset oValid", 32'(oValid), 32'd0);
    check("reset oBusy", 32'(oBusy), 32'd0);
    check("reset oDrop", 32'(oDrop), 32'd0);
    iReset = 1'b0;
    @(posedge iClk); #1;

    set_all(32'h0); m_mask = '1; m_bias = 32'h0;
    run_neuron("zero", 32'h0000_8000);
    set_all(32'h0000_1000);
    run_neuron("pos1p25", 32'h0000_C800);
    set_all(32'h7FFF_0000);
    run_neuron("sat_hi", 32'h0001_0000);
    set_all(32'h8000_0000);
    run_neuron("sat_lo", 32'h0000_0000);
    set_all(32'h1234_0000); m_lanes[0] = 32'hFFFF_0000; m_mask = 20'h00001;
    run_neuron("neg_mask", 32'h0000_4000);
    set_all(32'h0001_0000); m_mask = 20'h00001; m_bias = 32'h0001_0000;
    run_neuron("mask_bias", 32'h0000_E000);

    // Contention: second start while busy is dropped, then a start during oValid is accepted.
    set_all(32'h0000_1000); m_mask = '1; m_bias = 32'h0;
    load_inputs();
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    n = 0; vcnt = 0; vn = 0; drops = 0; drop_n = 0; vres = '0;
    while (n < 22) begin
      if (n == 5) begin
        set_all(32'h7FFF_0000); m_bias = 32'h0001_0000;
        load_inputs();
        iStart = 1'b1;
      end
      @(posedge iClk); #1;
      n++;
      iStart = 1'b0;
      if (oDrop) begin
        drops++;
        if (drop_n == 0) drop_n = n;
      end
      if (oValid) begin
        vcnt++;
        vn = n;
        vres = oResult;
      end
    end
    check("drop cycle", 32'(drop_n), 32'd6);
    check("drop count", 32'(drops), 32'd1);
    check("contend valid count", 32'(vcnt), 32'd1);
    check("contend valid cycle", 32'(vn), 32'd22);
    check("contend result", vres, 32'h0000_C800);
    exp_prev = 32'h0000_C800;
    set_all(32'h0); m_mask = '1; m_bias = 32'h0;
    run_neuron("b2b", 32'h0000_8000);

    // Reset mid-operation aborts and clears the result.
    set_all(32'h0000_1000);
    load_inputs();
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (9) begin @(posedge iClk); #1; end
    iReset = 1'b1;
    @(posedge iClk); #1;
    iReset = 1'b0;
    check("abort busy", 32'(oBusy), 32'd0);
    check("abort result", oResult, 32'h0);
    vcnt = 0;
    repeat (30) begin
      @(posedge iClk); #1;
      if (oValid) vcnt++;
    end
    check("abort no valid", 32'(vcnt), 32'd0);
    iReset = 1'b1;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iReset = 1'b0;
    iStart = 1'b0;
    check("reset over start busy", 32'(oBusy), 32'd0);
    exp_prev = '0;
    @(posedge iClk); #1;

`ifdef ANN_REDUCE_BYPASS_EN
    set_all(32'h0000_1000); m_mask = '1; m_bias = 32'h0; m_bypass = 1'b1;
    run_neuron("bypass", 32'h0001_4000);
    m_bypass = 1'b0;
`endif

    for (int k = 0; k < 16; k++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < LANES; i++) begin
        if (mode == 0) m_lanes[i] = 32'(int'($urandom_range(0, 'h18000)) - 'hC000);
        else if (mode == 1) m_lanes[i] = $urandom;
        else m_lanes[i] = 32'(int'($urandom_range(0, 'h8000)) - 'h4000);
      end
      m_mask = LANES'($urandom);
      m_bias = 32'(int'($urandom_range(0, 'hA0000)) - 'h50000);
`ifdef ANN_REDUCE_BYPASS_EN
      m_bypass = 1'($urandom_range(0, 1));
`endif
      run_neuron($sformatf("rand%0d", k), model_result());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
